// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard, redirect and trap sequencer for the three-stage F / D / E pipeline.
// It drives the operand forwarding selects, the fetch stall, the pipeline
// register flushes and the next-PC select. It runs interrupt entry and mret
// return with the CSR unit over a two-cycle handshake, and it keeps saturating
// stall and flush event counters.
//
// Build option:
//   PIPE_FWD_EN  defined   : an E-stage ALU result is forwarded to D.
//                undefined : for_A / for_B are tied to 0, and every register
//                            match is a one-cycle use hazard.
//
// Parameters:
//   CNT_W        width of the stall and flush event counters
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   rs1_D, rs2_D             source register indices of the D instruction
//   rs1_used_D, rs2_used_D   the D instruction reads rs1 / rs2
//   rd_E, reg_wr_E           destination index of the E instruction, write enable
//   wb_sel_E                 writeback source of E: 00 ALU, 01 load, 10 PC+4, 11 CSR
//   br_cond_D                the D instruction is a taken branch or jump
//   mret_D                   the D instruction is mret
//   irq                      level interrupt request, already masked
//   for_A, for_B             forward Alu_out_E to operand A / B
//   stall                    hold PC and the F->D register
//   flush_D, flush_E         load a bubble into the F->D / D->E register
//   br_taken                 next-PC select: 00 seq, 01 ALU target, 10 epc
//   trap_req, mret_req       one-cycle requests to the CSR unit
//   stall_cnt, flush_cnt     saturating event counters
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic             rs1_used_D,
  input  logic             rs2_used_D,
  input  logic [4:0]       rd_E,
  input  logic             reg_wr_E,
  input  logic [1:0]       wb_sel_E,
  input  logic             br_cond_D,
  input  logic             mret_D,
  input  logic             irq,
  output logic             for_A,
  output logic             for_B,
  output logic             stall,
  output logic             flush_D,
  output logic             flush_E,
  output logic [1:0]       br_taken,
  output logic             trap_req,
  output logic             mret_req,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_TRAP = 2'd1,
    S_MRET = 2'd2
  } state_t;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_ALU = 2'b01;
  localparam logic [1:0] PC_EPC = 2'b10;

  state_t state, state_nxt;
  logic   holdoff;

  // A source matches the E destination when it is really read, is not x0,
  // and E will really write it.
  logic match_a, match_b;
  logic fwd_a, fwd_b;
  logic haz_a, haz_b;
  logic use_hazard;

  assign match_a = rs1_used_D && (rs1_D != 5'd0) && (rs1_D == rd_E) && reg_wr_E;
  assign match_b = rs2_used_D && (rs2_D != 5'd0) && (rs2_D == rd_E) && reg_wr_E;

`ifdef PIPE_FWD_EN
  // Only an ALU result already exists at the E stage; load, PC+4 and CSR
  // results appear one cycle later, so those must stall instead.
  assign fwd_a = match_a && (wb_sel_E == 2'b00);
  assign fwd_b = match_b && (wb_sel_E == 2'b00);
  assign haz_a = match_a && (wb_sel_E != 2'b00);
  assign haz_b = match_b && (wb_sel_E != 2'b00);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
  assign haz_a = match_a;
  assign haz_b = match_b;
`endif

  assign use_hazard = haz_a || haz_b;

  // Steering outputs and next state. Every output is gated by rst_n, so the
  // pipeline sees a quiet controller for as long as reset is held.
  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    for_A     = 1'b0;
    for_B     = 1'b0;
    stall     = 1'b0;
    flush_D   = 1'b0;
    flush_E   = 1'b0;
    br_taken  = PC_SEQ;
    trap_req  = 1'b0;
    mret_req  = 1'b0;

    if (rst_n) begin
      unique case (state)
        S_RUN: begin
          if (use_hazard) begin
            // Hold D for one cycle and send a bubble down to E. The bubble
            // has reg_wr_E=0, so the same match cannot come back.
            stall   = 1'b1;
            flush_E = 1'b1;
          end else begin
            for_A = fwd_a;
            for_B = fwd_b;
            if (irq && !holdoff) begin
              // The D instruction is killed, even a taken branch, and the
              // CSR unit saves its PC as mepc.
              trap_req  = 1'b1;
              flush_D   = 1'b1;
              flush_E   = 1'b1;
              state_nxt = S_TRAP;
            end else if (mret_D) begin
              mret_req  = 1'b1;
              flush_D   = 1'b1;
              flush_E   = 1'b1;
              state_nxt = S_MRET;
            end else if (br_cond_D) begin
              br_taken = PC_ALU;
              flush_D  = 1'b1;
            end
          end
        end
        S_TRAP, S_MRET: begin
          // The CSR unit now drives epc. D holds a wrong-path instruction,
          // so all D inputs are ignored here.
          br_taken  = PC_EPC;
          flush_D   = 1'b1;
          flush_E   = 1'b1;
          state_nxt = S_RUN;
        end
        default: state_nxt = S_RUN;
      endcase
    end
  end

  // NOTE: registered state uses non-blocking assignments so that every
  // register samples values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_RUN;
      holdoff <= 1'b0;
    end else begin
      state   <= state_nxt;
      // Set during TRAP/MRET, so it covers exactly the first RUN cycle after
      // a redirect, then clears.
      holdoff <= (state != S_RUN);
    end
  end

  // Event counters stop at all-ones and never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((flush_D || flush_E) && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// Directed testbench for pipe_hazard_ctrl. The counters are 4 bits wide so that
// saturation can be reached in a few cycles. Expected outputs are hand-computed
// constants packed as
//   {for_A, for_B, stall, flush_D, flush_E, br_taken[1:0], trap_req, mret_req}.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int TB_CNT_W = 4;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs1_D, rs2_D, rd_E;
  logic       rs1_used_D, rs2_used_D, reg_wr_E;
  logic [1:0] wb_sel_E;
  logic       br_cond_D, mret_D, irq;
  logic       for_A, for_B, stall, flush_D, flush_E, trap_req, mret_req;
  logic [1:0] br_taken;
  logic [TB_CNT_W-1:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  logic [8:0] outs;
  assign outs = {for_A, for_B, stall, flush_D, flush_E, br_taken, trap_req, mret_req};

  pipe_hazard_ctrl #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_D(rs1_D), .rs2_D(rs2_D),
    .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D),
    .rd_E(rd_E), .reg_wr_E(reg_wr_E), .wb_sel_E(wb_sel_E),
    .br_cond_D(br_cond_D), .mret_D(mret_D), .irq(irq),
    .for_A(for_A), .for_B(for_B), .stall(stall),
    .flush_D(flush_D), .flush_E(flush_E), .br_taken(br_taken),
    .trap_req(trap_req), .mret_req(mret_req),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    rs1_D = 5'd0; rs2_D = 5'd0; rd_E = 5'd0;
    rs1_used_D = 1'b0; rs2_used_D = 1'b0; reg_wr_E = 1'b0;
    wb_sel_E = 2'b00; br_cond_D = 1'b0; mret_D = 1'b0; irq = 1'b0;
  endtask

  // Advance one clock and update the expected counters from the stall/flush
  // activity the bench expects for the cycle that just ended.
  task automatic step(input bit s, input bit f);
    @(posedge clk); #1;
    if (s && exp_stall < CNT_MAX) exp_stall++;
    if (f && exp_flush < CNT_MAX) exp_flush++;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if (outs !== 9'b0_0_0_0_0_00_0_0) begin
      n_err++; $display("FAIL reset_outs got=%b exp=%b", outs, 9'b0);
    end
    n_cmp++;
    if ({stall_cnt, flush_cnt} !== 8'h00) begin
      n_err++; $display("FAIL reset_cnt got=%h exp=00", {stall_cnt, flush_cnt});
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu_raw();
    idle_inputs();
    rd_E = 5'd5; reg_wr_E = 1'b1; wb_sel_E = 2'b00;
    rs1_D = 5'd5; rs1_used_D = 1'b1;
    #1;
    n_cmp++;
`ifdef PIPE_FWD_EN
    if (outs !== 9'b1_0_0_0_0_00_0_0) begin
      n_err++; $display("FAIL alu_raw_fwd got=%b exp=%b", outs, 9'b1_0_0_0_0_00_0_0);
    end
    step(0, 0);
`else
    if (outs !== 9'b0_0_1_0_1_00_0_0) begin
      n_err++; $display("FAIL alu_raw_stall got=%b exp=%b", outs, 9'b0_0_1_0_1_00_0_0);
    end
    step(1, 1);
`endif
    reg_wr_E = 1'b0;  // bubble now in E
    #1;
    n_cmp++;
    if (outs !== 9'b0) begin
      n_err++; $display("FAIL alu_raw_after got=%b exp=%b", outs, 9'b0);
    end
    n_cmp++;
    if (stall_cnt !== TB_CNT_W'(exp_stall)) begin
      n_err++; $display("FAIL alu_raw_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall);
    end
    step(0, 0);
  endtask

  task automatic test_load_use();
    idle_inputs();
    rd_E = 5'd7; reg_wr_E = 1'b1; wb_sel_E = 2'b01;
    rs2_D = 5'd7; rs2_used_D = 1'b1;
    #1;
    n_cmp++;
    if (outs !== 9'b0_0_1_0_1_00_0_0) begin
      n_err++; $display("FAIL load_use got=%b exp=%b", outs, 9'b0_0_1_0_1_00_0_0);
    end
    step(1, 1);
    reg_wr_E = 1'b0;
    #1;
    n_cmp++;
    if (outs !== 9'b0) begin
      n_err++; $display("FAIL load_use_after got=%b exp=%b", outs, 9'b0);
    end
    n_cmp++;
    if ({stall_cnt, flush_cnt} !== {TB_CNT_W'(exp_stall), TB_CNT_W'(exp_flush)}) begin
      n_err++; $display("FAIL load_use_cnt got=%0d/%0d exp=%0d/%0d",
                        stall_cnt, flush_cnt, exp_stall, exp_flush);
    end
    step(0, 0);
  endtask

  task automatic test_x0();
    idle_inputs();
    rd_E = 5'd0; reg_wr_E = 1'b1; wb_sel_E = 2'b00;
    rs1_D = 5'd0; rs1_used_D = 1'b1;
    #1;
    n_cmp++;
    if (outs !== 9'b0) begin
      n_err++; $display("FAIL x0_alu got=%b exp=%b", outs, 9'b0);
    end
    wb_sel_E = 2'b01; rs2_D = 5'd0; rs2_used_D = 1'b1;
    #1;
    n_cmp++;
    if (outs !== 9'b0) begin
      n_err++; $display("FAIL x0_load got=%b exp=%b", outs, 9'b0);
    end
    step(0, 0);
  endtask

  task automatic test_branch();
    idle_inputs();
    br_cond_D = 1'b1;
    #1;
    n_cmp++;
    if (outs !== 9'b0_0_0_1_0_01_0_0) begin
      n_err++; $display("FAIL branch got=%b exp=%b", outs, 9'b0_0_0_1_0_01_0_0);
    end
    step(0, 1);
    br_cond_D = 1'b0;
    #1;
    n_cmp++;
    if (flush_cnt !== TB_CNT_W'(exp_flush)) begin
      n_err++; $display("FAIL branch_flush_cnt got=%0d exp=%0d", flush_cnt, exp_flush);
    end
    // Branch together with a load-use hazard: hazard wins.
    br_cond_D = 1'b1;
    rd_E = 5'd9; reg_wr_E = 1'b1; wb_sel_E = 2'b01;
    rs1_D = 5'd9; rs1_used_D = 1'b1;
    #1;
    n_cmp++;
    if (outs !== 9'b0_0_1_0_1_00_0_0) begin
      n_err++; $display("FAIL branch_hazard got=%b exp=%b", outs, 9'b0_0_1_0_1_00_0_0);
    end
    step(1, 1);
    idle_inputs();
    step(0, 0);
  endtask

  task automatic test_irq();
    idle_inputs();
    irq = 1'b1; br_cond_D = 1'b1;
    #1;
    n_cmp++;
    if (outs !== 9'b0_0_0_1_1_00_1_0) begin
      n_err++; $display("FAIL irq_entry got=%b exp=%b", outs, 9'b0_0_0_1_1_00_1_0);
    end
    step(0, 1);
    br_cond_D = 1'b0;
    #1;
    n_cmp++;
    if (outs !== 9'b0_0_0_1_1_10_0_0) begin
      n_err++; $display("FAIL irq_trap_state got=%b exp=%b", outs, 9'b0_0_0_1_1_10_0_0);
    end
    step(0, 1);
    #1;
    n_cmp++;
    if (outs !== 9'b0) begin
      n_err++; $display("FAIL irq_holdoff got=%b exp=%b", outs, 9'b0);
    end
    step(0, 0);
    #1;
    n_cmp++;
    if (outs !== 9'b0_0_0_1_1_00_1_0) begin
      n_err++; $display("FAIL irq_retake got=%b exp=%b", outs, 9'b0_0_0_1_1_00_1_0);
    end
    step(0, 1);
    irq = 1'b0;
    step(0, 1);
    step(0, 0);
  endtask

  task automatic test_mret();
    idle_inputs();
    mret_D = 1'b1;
    #1;
    n_cmp++;
    if (outs !== 9'b0_0_0_1_1_00_0_1) begin
      n_err++; $display("FAIL mret_req got=%b exp=%b", outs, 9'b0_0_0_1_1_00_0_1);
    end
    step(0, 1);
    mret_D = 1'b0;
    #1;
    n_cmp++;
    if (outs !== 9'b0_0_0_1_1_10_0_0) begin
      n_err++; $display("FAIL mret_state got=%b exp=%b", outs, 9'b0_0_0_1_1_10_0_0);
    end
    step(0, 1);
    #1;
    n_cmp++;
    if (outs !== 9'b0) begin
      n_err++; $display("FAIL mret_return got=%b exp=%b", outs, 9'b0);
    end
    step(0, 0);
    // irq and mret together: trap wins, no mret_req.
    irq = 1'b1; mret_D = 1'b1;
    #1;
    n_cmp++;
    if (outs !== 9'b0_0_0_1_1_00_1_0) begin
      n_err++; $display("FAIL irq_mret got=%b exp=%b", outs, 9'b0_0_0_1_1_00_1_0);
    end
    step(0, 1);
    idle_inputs();
    step(0, 1);
    step(0, 0);
    n_cmp++;
    if ({stall_cnt, flush_cnt} !== {TB_CNT_W'(exp_stall), TB_CNT_W'(exp_flush)}) begin
      n_err++; $display("FAIL mid_cnt got=%0d/%0d exp=%0d/%0d",
                        stall_cnt, flush_cnt, exp_stall, exp_flush);
    end
  endtask

  task automatic test_reset_mid_mret();
    idle_inputs();
    mret_D = 1'b1;
    step(0, 1);
    mret_D = 1'b0;   // now in MRET
    rst_n = 1'b0;
    #1;
    exp_stall = 0; exp_flush = 0;
    n_cmp++;
    if (outs !== 9'b0) begin
      n_err++; $display("FAIL rst_mret_outs got=%b exp=%b", outs, 9'b0);
    end
    n_cmp++;
    if ({stall_cnt, flush_cnt} !== 8'h00) begin
      n_err++; $display("FAIL rst_mret_cnt got=%h exp=00", {stall_cnt, flush_cnt});
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (outs !== 9'b0) begin
        n_err++; $display("FAIL rst_mret_after%0d got=%b exp=%b", i, outs, 9'b0);
      end
      step(0, 0);
    end
  endtask

  task automatic test_saturate();
    idle_inputs();
    rd_E = 5'd3; reg_wr_E = 1'b1; wb_sel_E = 2'b11;
    rs1_D = 5'd3; rs1_used_D = 1'b1;
    for (int i = 0; i < CNT_MAX + 5; i++) step(1, 1);
    idle_inputs();
    #1;
    n_cmp++;
    if (stall_cnt !== TB_CNT_W'(CNT_MAX) || exp_stall != CNT_MAX) begin
      n_err++; $display("FAIL sat_stall got=%0d exp=%0d", stall_cnt, CNT_MAX);
    end
    n_cmp++;
    if (flush_cnt !== TB_CNT_W'(CNT_MAX)) begin
      n_err++; $display("FAIL sat_flush got=%0d exp=%0d", flush_cnt, CNT_MAX);
    end
  endtask

  initial begin
    test_reset();
    test_alu_raw();
    test_load_use();
    test_x0();
    test_branch();
    test_irq();
    test_mret();
    test_reset_mid_mret();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard, redirect and trap sequencer for the three-stage (F / D / E) pipeline. Drives the operand forwarding selects, the fetch stall, the pipeline-register flushes and the 2-bit next-PC select (00 sequential, 01 ALU target, 10 epc). Sequences interrupt entry and `mret` return with the CSR unit over a two-cycle handshake. Also keeps saturating stall and flush event counters.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rs1_D, rs2_D  in  5  source register indices of the D instruction.
- rs1_used_D, rs2_used_D  in  1  the D instruction reads rs1 / rs2.
- rd_E  in  5  destination register index of the E instruction.
- reg_wr_E  in  1  the E instruction writes rd_E.
- wb_sel_E  in  2  writeback source of E: 00 ALU, 01 load, 10 PC+4, 11 CSR.
- br_cond_D  in  1  the D instruction is a taken branch or jump.
- mret_D  in  1  the D instruction is `mret`.
- irq  in  1  level interrupt request, already masked by mie/mstatus.
- for_A, for_B  out  1  forward Alu_out_E to operand A / B.
- stall  out  1  hold PC and the F→D register.
- flush_D  out  1  load a bubble into the F→D register.
- flush_E  out  1  load a bubble into the D→E register.
- br_taken  out  2  next-PC select.
- trap_req  out  1  one-cycle pulse; CSR unit saves mepc=PC_D and drives epc=mtvec.
- mret_req  out  1  one-cycle pulse; CSR unit drives epc=mepc.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

## Operation
- A source matches when it is used, its index is nonzero, it equals rd_E, and reg_wr_E=1.
- A match with wb_sel_E=00 forwards: for_A or for_B=1.
- A match with any other wb_sel_E is a use hazard:
  - stall=1, flush_E=1 for the cycle.
  - for_A/for_B=0.
  - br_cond_D, mret_D and irq are ignored that cycle.
- Index 0 never forwards or stalls.
- FSM states:
  - RUN (reset state).
    - irq with no hazard and holdoff=0: trap_req=1, flush_D=1, flush_E=1, br_taken=00, go TRAP.
    - Otherwise mret_D with no hazard: mret_req=1, flush_D=1, flush_E=1, go MRET.
    - Otherwise br_cond_D with no hazard: br_taken=01, flush_D=1, stay in RUN.
  - TRAP: br_taken=10, flush_D=1, flush_E=1; all D inputs ignored; go RUN, holdoff←1.
  - MRET: same outputs as TRAP; go RUN, holdoff←1.
- holdoff blocks irq for the first RUN cycle after a redirect; it clears after that cycle.
- Priority: use hazard > irq > mret_D > br_cond_D.
  - irq and br_cond_D together: the branch is killed; mepc points at it.
  - irq and mret_D together: the trap is taken; mret_req stays 0.
- stall_cnt increments on every stall=1 cycle.
- flush_cnt increments on every cycle with flush_D or flush_E asserted.
- Both counters saturate at 2^CNT_W−1 and never wrap.

## Timing
- All steering outputs are combinational from the inputs and the registered state: FSM state, holdoff and counters.
- Zero-cycle latency to the datapath muxes.
- A use hazard costs exactly one cycle. The bubble enters E with reg_wr_E=0, so the hazard cannot re-match.
- A taken branch costs one bubble.
- Trap entry and `mret` each cost two cycles, RUN→TRAP/MRET→RUN. The first instruction from the redirect target reaches D on the cycle after TRAP/MRET.
- trap_req and mret_req are high for exactly one cycle and never both in the same cycle.
- Reset, asynchronous assert:
  - FSM→RUN, holdoff=0, counters=0.
  - All 1-bit outputs 0, br_taken=00.
  - Reset mid-TRAP/MRET abandons the redirect; no second request pulse is issued.
- Deassertion takes effect on the first rising edge of clk.

## Configuration
- PIPE_FWD_EN defined: forwarding as specified above.
- PIPE_FWD_EN undefined:
  - for_A and for_B are tied to 0.
  - Every match, including wb_sel_E=00, is a use hazard with a one-cycle stall.
  - All other behaviour is unchanged.

## Test plan
- ALU RAW, x5 written in E with wb_sel_E=00, rs1_D=5 -> for_A=1, stall=0; without PIPE_FWD_EN, stall=1 for one cycle, stall_cnt=1.
- Load-use, wb_sel_E=01, rd_E=7, rs2_D=7 -> stall=1 and flush_E=1 for one cycle, for_B=0; next cycle with reg_wr_E=0: stall=0.
- rd_E=0 with rs1_D=0 and reg_wr_E=1 -> for_A=0, stall=0.
- br_cond_D=1 with no hazard -> br_taken=01, flush_D=1, flush_cnt increments by 1; with a simultaneous load-use hazard -> br_taken=00, stall=1.
- irq with br_cond_D=1 -> trap_req pulse, br_taken=00; next cycle br_taken=10, flush_D=1, flush_E=1; irq held high in the following RUN cycle is ignored, then a trap is taken the cycle after.
- mret_D -> mret_req pulse, then br_taken=10 for one cycle; rst_n=0 during the MRET cycle -> all outputs 0 and no further request pulses.
